// File: rtl/requant_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : requant_writeback
//  Purpose  : Takes signed dot-product results (one per output row), adds a
//             per-row bias, scales with round-half-up right shift, applies
//             optional ReLU and signed saturation, then writes the quantized
//             word to output memory. Results are buffered in a small FIFO and
//             rows are counted per layer; layer_done pulses once the last row
//             write has been accepted.
//  Ports    : clk/rst            - clock, asynchronous active-high reset
//             layer_start + cfg  - begin layer, latch num_rows/base/scale/
//                                  shift/relu_en, flush in-flight work
//             in_valid/in_data   - incoming 2*DATA_WIDTH signed result
//             bias_rd_*          - bias memory read (data one cycle later)
//             out_wr_*           - output write, held until out_wr_ready
//             busy/layer_done    - layer active / end-of-layer pulse
//             overflow_err       - sticky: result dropped
//  Revision : 1.0 - initial release
// ============================================================================
module requant_writeback #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SCALE_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    layer_start,
    input  logic [ADDR_WIDTH-1:0]   num_rows,
    input  logic [ADDR_WIDTH-1:0]   out_base_addr,
    input  logic [SCALE_WIDTH-1:0]  scale,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic                    bias_rd_en,
    output logic [ADDR_WIDTH-1:0]   bias_rd_addr,
    input  logic [DATA_WIDTH-1:0]   bias_rd_data,
    output logic                    out_wr_en,
    output logic [ADDR_WIDTH-1:0]   out_wr_addr,
    output logic [OUT_WIDTH-1:0]    out_wr_data,
    input  logic                    out_wr_ready,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    overflow_err
);

    localparam int IN_W   = 2*DATA_WIDTH;
    localparam int SUM_W  = IN_W + 1;
    localparam int PROD_W = SUM_W + SCALE_WIDTH + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic signed [PROD_W-1:0] c_out_max =
        {{(PROD_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] c_out_min =
        {{(PROD_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] c_sat_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_sat_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [PROD_W-1:0]    c_one     = PROD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BIAS_RD = 2'd1,
        ST_SCALE   = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t                  r_state_q,    w_state_d;
    logic                    r_active_q,   w_active_d;
    logic [ADDR_WIDTH-1:0]   r_num_rows_q, w_num_rows_d;
    logic [ADDR_WIDTH-1:0]   r_base_q,     w_base_d;
    logic [SCALE_WIDTH-1:0]  r_scale_q,    w_scale_d;
    logic [4:0]              r_shift_q,    w_shift_d;
    logic                    r_relu_q,     w_relu_d;
    logic [ADDR_WIDTH-1:0]   r_row_q,      w_row_d;
    logic [IN_W-1:0]         r_work_q,     w_work_d;
    logic [OUT_WIDTH-1:0]    r_out_data_q, w_out_data_d;
    logic                    r_done_q,     w_done_d;
    logic                    r_ovf_q,      w_ovf_d;
    logic [PTR_W-1:0]        r_wr_ptr_q,   w_wr_ptr_d;
    logic [PTR_W-1:0]        r_rd_ptr_q,   w_rd_ptr_d;
    logic [CNT_W-1:0]        r_count_q,    w_count_d;
    logic [IN_W-1:0]         r_fifo_q [FIFO_DEPTH];

    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;

    // Datapath: widths are chosen so no intermediate can wrap
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_prod;
    logic        [PROD_W-1:0] w_rnd;
    logic signed [PROD_W-1:0] w_round;
    logic signed [PROD_W-1:0] w_shifted;
    logic signed [PROD_W-1:0] w_relu;
    logic [OUT_WIDTH-1:0]     w_sat;

    always_comb begin
        w_sum = {r_work_q[IN_W-1], r_work_q}
              + {{(SUM_W-DATA_WIDTH){bias_rd_data[DATA_WIDTH-1]}}, bias_rd_data};
        w_prod = {{(PROD_W-SUM_W){w_sum[SUM_W-1]}}, w_sum}
               * {{(PROD_W-SCALE_WIDTH){1'b0}}, r_scale_q};
        w_rnd = '0;
        if (r_shift_q != 5'd0) begin
            w_rnd = c_one << (r_shift_q - 5'd1);
        end
        w_round   = w_prod + w_rnd;
        w_shifted = w_round >>> r_shift_q;
        w_relu    = (r_relu_q && w_shifted[PROD_W-1]) ? '0 : w_shifted;
        if (w_relu > c_out_max) begin
            w_sat = c_sat_max;
        end else if (w_relu < c_out_min) begin
            w_sat = c_sat_min;
        end else begin
            w_sat = w_relu[OUT_WIDTH-1:0];
        end
    end

    assign w_full  = (r_count_q == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count_q == '0);

    always_comb begin
        w_state_d    = r_state_q;
        w_active_d   = r_active_q;
        w_num_rows_d = r_num_rows_q;
        w_base_d     = r_base_q;
        w_scale_d    = r_scale_q;
        w_shift_d    = r_shift_q;
        w_relu_d     = r_relu_q;
        w_row_d      = r_row_q;
        w_work_d     = r_work_q;
        w_out_data_d = r_out_data_q;
        w_done_d     = 1'b0;
        w_ovf_d      = r_ovf_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        if (layer_start) begin
            // Flush everything; a zero-row layer completes immediately.
            w_state_d    = ST_IDLE;
            w_num_rows_d = num_rows;
            w_base_d     = out_base_addr;
            w_scale_d    = scale;
            w_shift_d    = shift;
            w_relu_d     = relu_en;
            w_active_d   = (num_rows != '0);
            w_done_d     = (num_rows == '0);
            w_row_d      = '0;
            w_ovf_d      = 1'b0;
            w_wr_ptr_d   = '0;
            w_rd_ptr_d   = '0;
            w_count_d    = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (r_active_q && !w_empty) begin
                        w_pop     = 1'b1;
                        w_work_d  = r_fifo_q[r_rd_ptr_q];
                        w_state_d = ST_BIAS_RD;
                    end
                end
                ST_BIAS_RD: w_state_d = ST_SCALE;
                ST_SCALE: begin
                    w_out_data_d = w_sat;
                    w_state_d    = ST_WRITE;
                end
                ST_WRITE: begin
                    if (out_wr_ready) begin
                        w_state_d = ST_IDLE;
                        if (r_row_q == r_num_rows_q - 1'b1) begin
                            w_row_d    = '0;
                            w_active_d = 1'b0;
                            w_done_d   = 1'b1;
                        end else begin
                            w_row_d = r_row_q + 1'b1;
                        end
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase

            // A full FIFO still accepts when the head leaves this cycle.
            if (in_valid) begin
                if (!r_active_q || (w_full && !w_pop)) begin
                    w_ovf_d = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end

            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            end
            w_count_d = r_count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_active_q   <= 1'b0;
            r_num_rows_q <= '0;
            r_base_q     <= '0;
            r_scale_q    <= '0;
            r_shift_q    <= '0;
            r_relu_q     <= 1'b0;
            r_row_q      <= '0;
            r_work_q     <= '0;
            r_out_data_q <= '0;
            r_done_q     <= 1'b0;
            r_ovf_q      <= 1'b0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_q[i] <= '0;
            end
        end else begin
            r_state_q    <= w_state_d;
            r_active_q   <= w_active_d;
            r_num_rows_q <= w_num_rows_d;
            r_base_q     <= w_base_d;
            r_scale_q    <= w_scale_d;
            r_shift_q    <= w_shift_d;
            r_relu_q     <= w_relu_d;
            r_row_q      <= w_row_d;
            r_work_q     <= w_work_d;
            r_out_data_q <= w_out_data_d;
            r_done_q     <= w_done_d;
            r_ovf_q      <= w_ovf_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            if (w_push) begin
                r_fifo_q[r_wr_ptr_q] <= in_data;
            end
        end
    end

    // Strobes decode straight from state so reset removes them at once.
    assign bias_rd_en   = (r_state_q == ST_BIAS_RD);
    assign bias_rd_addr = r_row_q;
    assign out_wr_en    = (r_state_q == ST_WRITE);
    assign out_wr_addr  = r_base_q + r_row_q;
    assign out_wr_data  = r_out_data_q;
    assign busy         = r_active_q;
    assign layer_done   = r_done_q;
    assign overflow_err = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_requant_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_requant_writeback
//  Purpose  : Self-checking bench for requant_writeback. Stimulus pushes the
//             hand-computed write (address, data) into a queue; a monitor
//             pops and compares on every accepted output write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_requant_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        layer_start;
    logic [9:0]  num_rows;
    logic [9:0]  out_base_addr;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
    logic        in_valid;
    logic [31:0] in_data;
    logic        bias_rd_en;
    logic [9:0]  bias_rd_addr;
    logic [15:0] bias_rd_data;
    logic        out_wr_en;
    logic [9:0]  out_wr_addr;
    logic [15:0] out_wr_data;
    logic        out_wr_ready;
    logic        busy;
    logic        layer_done;
    logic        overflow_err;

    requant_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .layer_start  (layer_start),
        .num_rows     (num_rows),
        .out_base_addr(out_base_addr),
        .scale        (scale),
        .shift        (shift),
        .relu_en      (relu_en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .bias_rd_en   (bias_rd_en),
        .bias_rd_addr (bias_rd_addr),
        .bias_rd_data (bias_rd_data),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .out_wr_ready (out_wr_ready),
        .busy         (busy),
        .layer_done   (layer_done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Bias memory model: one-cycle read latency.
    logic [15:0] bias_mem [0:1023];
    always @(posedge clk) begin
        if (bias_rd_en) bias_rd_data <= bias_mem[bias_rd_addr];
    end

    typedef struct {
        int addr;
        int data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    int cnt;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_wr_en && out_wr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {54'd0, out_wr_addr}, mon_e.addr);
                check("wr_data", $signed(out_wr_data), mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start(input int rows, input int base, input int sc,
                         input int sh, input bit relu);
        layer_start   = 1'b1;
        num_rows      = 10'(rows);
        out_base_addr = 10'(base);
        scale         = 16'(sc);
        shift         = 5'(sh);
        relu_en       = relu;
        tick();
        layer_start   = 1'b0;
    endtask

    task automatic pulse(input int d);
        in_valid = 1'b1;
        in_data  = 32'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run(input int n, output int p);
        p = 0;
        repeat (n) begin
            tick();
            if (layer_done) p++;
        end
    endtask

    task automatic clr_bias();
        for (int i = 0; i < 1024; i++) bias_mem[i] = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; layer_start = 0; num_rows = 0; out_base_addr = 0;
        scale = 0; shift = 0; relu_en = 0; in_valid = 0; in_data = 0;
        out_wr_ready = 1'b1;
        clr_bias();
        tick(); tick();
        check("reset_outputs",
              {59'd0, out_wr_en, bias_rd_en, busy, layer_done, overflow_err}, 0);
        rst = 1'b0;
        tick();

        // (1000 + 24) * 3 = 3072, +2, >>2 -> 768; 4-cycle latency
        bias_mem[0] = 16'd24;
        start(1, 5, 3, 2, 0);
        check("busy_after_start", busy, 1);
        expect_wr(5, 768);
        pulse(1000);
        tick(); tick();
        check("latency_wr_low_c3", out_wr_en, 0);
        tick();
        check("latency_wr_high_c4", out_wr_en, 1);
        tick();
        check("layer_done_pulse", layer_done, 1);
        check("busy_low_after_done", busy, 0);
        tick();
        check("layer_done_one_cycle", layer_done, 0);

        // -10 >> 2 with rounding -> -2; with ReLU -> 0
        clr_bias();
        start(1, 10, 1, 2, 0);
        expect_wr(10, -2);
        pulse(-10);
        run(12, pulses);
        check("neg_round_done", pulses, 1);
        start(1, 11, 1, 2, 1);
        expect_wr(11, 0);
        pulse(-10);
        run(12, pulses);
        check("relu_done", pulses, 1);

        // saturation both ways
        start(2, 20, 1, 0, 0);
        expect_wr(20, 32767);
        expect_wr(21, -32768);
        pulse(32'h0100_0000);
        pulse(32'hFF00_0000);
        run(20, pulses);
        check("sat_done", pulses, 1);

        // three back-to-back results under backpressure
        // (10+1)*2+1>>1=11, (20-5)*2+1>>1=15, (-300+100)*2+1>>1=-200
        bias_mem[0] = 16'd1;
        bias_mem[1] = -16'sd5;
        bias_mem[2] = 16'd100;
        start(3, 100, 2, 1, 0);
        out_wr_ready = 1'b0;
        expect_wr(100, 11);
        expect_wr(101, 15);
        expect_wr(102, -200);
        pulse(10); pulse(20); pulse(-300);
        repeat (10) tick();
        check("held_wr_en", out_wr_en, 1);
        check("held_wr_addr", {54'd0, out_wr_addr}, 100);
        out_wr_ready = 1'b1;
        run(30, pulses);
        check("three_rows_single_done", pulses, 1);
        check("three_rows_no_ovf", overflow_err, 0);

        // six consecutive results, no acceptance: the first moves into the
        // work register, four fill the FIFO, the sixth is dropped
        clr_bias();
        start(5, 200, 1, 0, 0);
        out_wr_ready = 1'b0;
        for (int i = 1; i <= 6; i++) pulse(i);
        check("fifo_full_ovf", overflow_err, 1);
        for (int i = 1; i <= 5; i++) expect_wr(200 + i - 1, i);
        out_wr_ready = 1'b1;
        run(40, pulses);
        check("overflow_layer_done", pulses, 1);

        // abort mid-WRITE, then address wrap on the new layer
        start(2, 300, 1, 0, 0);
        out_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(7 + i);
        check("abort_pre_wr_en", out_wr_en, 1);
        check("abort_pre_ovf", overflow_err, 1);
        bias_mem[0] = 16'd1;
        bias_mem[1] = 16'd2;
        bias_mem[2] = 16'd3;
        start(3, 1022, 1, 0, 0);
        check("abort_wr_en_low", out_wr_en, 0);
        check("abort_ovf_cleared", overflow_err, 0);
        check("abort_busy", busy, 1);
        cnt = 0;
        repeat (3) begin
            tick();
            if (bias_rd_en || out_wr_en) cnt++;
        end
        check("abort_fifo_empty", cnt, 0);
        out_wr_ready = 1'b1;
        expect_wr(1022, 12);
        expect_wr(1023, 24);
        expect_wr(0, 36);
        pulse(11); pulse(22); pulse(33);
        run(30, pulses);
        check("wrap_done", pulses, 1);

        // result after the layer ended is dropped
        pulse(99);
        check("extra_result_ovf", overflow_err, 1);

        // zero-row layer
        start(0, 0, 1, 0, 0);
        check("zero_rows_done", layer_done, 1);
        check("zero_rows_busy", busy, 0);
        check("zero_rows_ovf_cleared", overflow_err, 0);

        // asynchronous reset in the middle of a write
        start(1, 400, 1, 0, 0);
        out_wr_ready = 1'b0;
        pulse(5);
        tick(); tick(); tick();
        check("async_pre_wr_en", out_wr_en, 1);
        #2 rst = 1'b1;
        #1 check("async_wr_en_drop", out_wr_en, 0);
        #2 rst = 1'b0;
        run(6, pulses);
        check("async_no_done", pulses, 0);
        check("async_busy", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
